imem_read_arbiter: RTL and testbench
====================================

IMEM_READ_ARBITER -- requirements
Module: imem_read_arbiter

Interface
REQ-001 SHALL have parameter AXI_AWIDTH, default 4, address width of all AR channels.
REQ-002 SHALL have parameter AXI_DWIDTH, default 32, data width of all R channels.
REQ-003 SHALL have port AXI_ACLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port AXI_ARESET  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports M0_ARADDR in AXI_AWIDTH, M0_ARVALID in 1, M0_ARREADY out 1, M0_RDATA out AXI_DWIDTH, M0_RRESP out 2, M0_RVALID out 1, M0_RREADY in 1  requester 0 (instruction fetch).
REQ-006 SHALL have the identical M1_* port set  requester 1 (load path into instruction memory).
REQ-007 SHALL have ports S_ARADDR out AXI_AWIDTH, S_ARVALID out 1, S_ARREADY in 1, S_RDATA in AXI_DWIDTH, S_RRESP in 2, S_RVALID in 1, S_RREADY out 1  shared instruction-memory read slave.

Function
REQ-008 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE, with one outstanding transaction maximum.
REQ-009 In IDLE, SHALL select a winner among requesters with ARVALID high, assert that requester's ARREADY combinationally in the same cycle, latch its ARADDR and grant index, and move to ADDR.
REQ-010 In IDLE with no ARVALID, SHALL stay in IDLE with both M*_ARREADY low.
REQ-011 In ADDR, SHALL drive S_ARVALID=1 and S_ARADDR=latched address, and SHALL hold both stable until S_ARVALID&S_ARREADY is sampled high, then move to DATA.
REQ-012 In ADDR, SHALL drive S_RREADY=1, because the slave launches RVALID only when it samples ARVALID, ARREADY and RREADY high together.
REQ-013 In DATA, SHALL pass S_RDATA and S_RRESP combinationally to the granted requester, drive its M*_RVALID=S_RVALID, and drive S_RREADY=granted M*_RREADY.
REQ-014 In DATA, SHALL return to IDLE on the edge where S_RVALID&S_RREADY is high.
REQ-015 The non-granted requester SHALL see RVALID=0 and ARREADY=0 at all times outside its own grant.
REQ-016 In IDLE, SHALL drive S_RREADY=1 and discard any S_RVALID, so that a stray response is drained.
REQ-017 A requester whose ARVALID is held across a transaction SHALL be re-evaluated in the next IDLE cycle; a new grant SHALL never begin before the previous R handshake completes.
REQ-018 Minimum latency SHALL be: M_AR handshake at cycle N, S_ARVALID high at N+1.
REQ-019 M*_RDATA SHALL be don't-care while the corresponding M*_RVALID is low.
REQ-020 M*_RRESP SHALL pass through unmodified, including non-zero values.

Reset
REQ-021 While AXI_ARESET is high at a clock edge, SHALL go to IDLE, clear S_ARVALID and both M*_RVALID and M*_ARREADY, zero the latched address, and set the priority pointer to requester 0.
REQ-022 A reset asserted in ADDR or DATA SHALL abandon the transaction with no response delivered; the slave is held in reset by the same reset signal, inverted.

Configuration
REQ-023 Macro IMEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-024 With IMEM_ARB_ROUND_ROBIN_EN defined, when both requesters are valid, the one not granted last SHALL win; the pointer SHALL update on each accepted M_AR handshake.
REQ-025 Without IMEM_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win ties (fixed priority); the pointer logic SHALL be absent.

Verification
REQ-026 Single request, M0 only: M0_ARADDR=4'h3, slave returns 32'h00000013 -> M0_ARREADY pulses 1 cycle, S_ARADDR=3 from N+1, M0_RVALID with RDATA=32'h00000013 RRESP=0, M1_RVALID stays 0.
REQ-027 Simultaneous M0 (addr 1) and M1 (addr 2), both held, round-robin build -> grants M0, M1, M0 in order with matching data; fixed build -> M0 is granted every time while valid.
REQ-028 Backpressure: M1 holds RREADY=0 for 5 cycles after S_RVALID -> S_RREADY=0, S_RVALID and M1_RDATA held stable, FSM stays in DATA, no new grant until the handshake.
REQ-029 Slow slave: S_ARREADY delayed 3 cycles -> S_ARVALID and S_ARADDR stable throughout, S_RREADY=1 throughout ADDR.
REQ-030 Reset mid-DATA: assert AXI_ARESET with M0 awaiting its response -> next cycle all valids 0, FSM IDLE, and a subsequent M1 request to addr 4'hF completes normally.
REQ-031 Error passthrough: slave returns RRESP=2'b10 -> M0_RRESP=2'b10 in the same cycle as M0_RVALID.

Source files
------------

// File: rtl/imem_read_arbiter_if.sv
// rtl/imem_read_arbiter_if.sv - AR/R read-channel bundle shared by requesters and the instruction-memory slave
interface imem_read_arbiter_if #(
   parameter int AXI_AWIDTH = 4,
   parameter int AXI_DWIDTH = 32
);
   logic [AXI_AWIDTH-1:0] ARADDR;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [AXI_DWIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RVALID;
   logic                  RREADY;

   // Issues AR, consumes R (a requester, or the arbiter towards the memory)
   modport master (
      output ARADDR, ARVALID, RREADY,
      input  ARREADY, RDATA, RRESP, RVALID
   );

   // Accepts AR, produces R (the memory, or the arbiter towards a requester)
   modport slave (
      input  ARADDR, ARVALID, RREADY,
      output ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/imem_read_arbiter.sv
// rtl/imem_read_arbiter.sv - two-requester read arbiter for instruction memory; IMEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module imem_read_arbiter #(
   parameter int AXI_AWIDTH = 4,
   parameter int AXI_DWIDTH = 32
) (
   input  logic                 AXI_ACLK,
   input  logic                 AXI_ARESET,
   imem_read_arbiter_if.slave   M0,
   imem_read_arbiter_if.slave   M1,
   imem_read_arbiter_if.master  S
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;

   logic [AXI_AWIDTH-1:0] addr_q;
   logic                  grant_q;      // 0 = M0 owns the transaction, 1 = M1
   logic                  win_sel;      // requester picked this cycle when in IDLE
   logic                  req_any;
   logic                  ar_accept;    // an M_AR handshake happens on this edge
   logic                  r_done;       // the slave R handshake happens on this edge
   logic [AXI_DWIDTH-1:0] rdata_pass;

   assign req_any    = M0.ARVALID | M1.ARVALID;
   // Reset gating keeps a requester from seeing ARREADY while the arbiter is being cleared
   assign ar_accept  = (state_q == ST_IDLE) && req_any && !AXI_ARESET;
   assign r_done     = (state_q == ST_DATA) && S.RVALID && S.RREADY;
   assign rdata_pass = S.RDATA;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
   logic prio_q;   // requester preferred when both are valid

   // Pick the winner: the preferred requester on a tie, otherwise whoever is valid
   always_comb begin
      if (M0.ARVALID && M1.ARVALID) begin
         win_sel = prio_q;
      end else begin
         win_sel = !M0.ARVALID;
      end
   end

   // Move preference to the requester that did not just win
   always_ff @(posedge AXI_ACLK) begin
      if (AXI_ARESET) begin
         prio_q <= 1'b0;
      end else if (ar_accept) begin
         prio_q <= !win_sel;
      end
   end
`else
   // Fixed priority: M0 wins whenever it is valid
   always_comb begin
      win_sel = !M0.ARVALID;
   end
`endif

   // State register
   always_ff @(posedge AXI_ACLK) begin
      if (AXI_ARESET) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: one transaction in flight, idle cycle between responses and new grants
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ar_accept) begin
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (S.ARREADY) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (r_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Capture the winning address and grant index on the accepted M_AR handshake
   always_ff @(posedge AXI_ACLK) begin
      if (AXI_ARESET) begin
         addr_q  <= '0;
         grant_q <= 1'b0;
      end else if (ar_accept) begin
         addr_q  <= win_sel ? M1.ARADDR : M0.ARADDR;
         grant_q <= win_sel;
      end
   end

   // Handshake outputs per state; RREADY stays high outside DATA so stray responses drain
   always_comb begin
      M0.ARREADY = 1'b0;
      M1.ARREADY = 1'b0;
      M0.RVALID  = 1'b0;
      M1.RVALID  = 1'b0;
      S.ARVALID  = 1'b0;
      S.RREADY   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            S.RREADY = 1'b1;
            if (ar_accept) begin
               if (win_sel) begin
                  M1.ARREADY = 1'b1;
               end else begin
                  M0.ARREADY = 1'b1;
               end
            end
         end
         ST_ADDR: begin
            // The slave only launches R when it sees ARVALID, ARREADY and RREADY together
            S.ARVALID = 1'b1;
            S.RREADY  = 1'b1;
         end
         ST_DATA: begin
            if (grant_q) begin
               M1.RVALID = S.RVALID;
               S.RREADY  = M1.RREADY;
            end else begin
               M0.RVALID = S.RVALID;
               S.RREADY  = M0.RREADY;
            end
         end
         default: begin
            S.RREADY = 1'b1;
         end
      endcase
   end

   // Address and read data/response are plain passthroughs; RVALID qualifies them
   assign S.ARADDR = addr_q;
   assign M0.RDATA = rdata_pass;
   assign M1.RDATA = rdata_pass;
   assign M0.RRESP = S.RRESP;
   assign M1.RRESP = S.RRESP;

endmodule

// File: tb/tb_imem_read_arbiter.sv
// tb/tb_imem_read_arbiter.sv - directed and randomized checks of imem_read_arbiter against a transaction-level model
module tb_imem_read_arbiter;

   localparam int AW = 4;
   localparam int DW = 32;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   imem_read_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) m0_if ();
   imem_read_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) m1_if ();
   imem_read_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) s_if ();

   imem_read_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) dut (
      .AXI_ACLK   (clk),
      .AXI_ARESET (rst),
      .M0         (m0_if),
      .M1         (m1_if),
      .S          (s_if)
   );

   always #5 clk = !clk;

   // Slave memory contents and its AR acceptance delay
   logic [DW-1:0] mem      [16];
   logic [1:0]    resp_mem [16];
   int            ar_delay = 0;
   int            ar_cnt   = 0;

   // Slave: samples handshakes at the edge, updates its outputs 1 time unit later
   always @(posedge clk) begin
      logic          ar_hs;
      logic          r_hs;
      logic          av;
      logic [AW-1:0] a;
      ar_hs = s_if.ARVALID && s_if.ARREADY && s_if.RREADY;
      r_hs  = s_if.RVALID && s_if.RREADY;
      av    = s_if.ARVALID;
      a     = s_if.ARADDR;
      #1;
      if (rst) begin
         s_if.ARREADY = 1'b0;
         s_if.RVALID  = 1'b0;
         s_if.RDATA   = '0;
         s_if.RRESP   = 2'b00;
         ar_cnt       = 0;
      end else begin
         if (r_hs) begin
            s_if.RVALID = 1'b0;
            s_if.RDATA  = $urandom;
         end
         if (ar_hs) begin
            s_if.RVALID  = 1'b1;
            s_if.RDATA   = mem[a];
            s_if.RRESP   = resp_mem[a];
            ar_cnt       = 0;
            s_if.ARREADY = (ar_delay == 0);
         end else if (av) begin
            ar_cnt       = ar_cnt + 1;
            s_if.ARREADY = (ar_cnt >= ar_delay);
         end else begin
            ar_cnt       = 0;
            s_if.ARREADY = (ar_delay == 0);
         end
      end
   end

   // Advance to the drive point of the next cycle (2 units after the edge)
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_rvalid(input int idx, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         #1;
         if ((idx == 0 && m0_if.RVALID === 1'b1) || (idx == 1 && m1_if.RVALID === 1'b1)) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m0_if.ARVALID = 1'b1; m0_if.ARADDR = 4'h5; m0_if.RREADY = 1'b1;
      m1_if.ARVALID = 1'b1; m1_if.ARADDR = 4'h6; m1_if.RREADY = 1'b1;
      tick();
      tick();
      #1;
      tests++; if (m0_if.ARREADY !== 1'b0) begin fails++; $display("FAIL reset_m0_arready got %b exp 0", m0_if.ARREADY); end
      tests++; if (m1_if.ARREADY !== 1'b0) begin fails++; $display("FAIL reset_m1_arready got %b exp 0", m1_if.ARREADY); end
      tests++; if (s_if.ARVALID !== 1'b0) begin fails++; $display("FAIL reset_s_arvalid got %b exp 0", s_if.ARVALID); end
      tests++; if (m0_if.RVALID !== 1'b0 || m1_if.RVALID !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b%b exp 00", m0_if.RVALID, m1_if.RVALID); end
      tests++; if (s_if.ARADDR !== 4'h0) begin fails++; $display("FAIL reset_s_araddr got %h exp 0", s_if.ARADDR); end
      tests++; if (s_if.RREADY !== 1'b1) begin fails++; $display("FAIL reset_s_rready got %b exp 1", s_if.RREADY); end
      m0_if.ARVALID = 1'b0;
      m1_if.ARVALID = 1'b0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      bit ok;
      mem[3] = 32'h00000013; resp_mem[3] = 2'b00;
      tick();
      m0_if.ARADDR = 4'h3; m0_if.ARVALID = 1'b1; m0_if.RREADY = 1'b1;
      #1;
      tests++; if (m0_if.ARREADY !== 1'b1) begin fails++; $display("FAIL single_m0_arready got %b exp 1", m0_if.ARREADY); end
      tests++; if (m1_if.ARREADY !== 1'b0) begin fails++; $display("FAIL single_m1_arready got %b exp 0", m1_if.ARREADY); end
      tick();
      m0_if.ARVALID = 1'b0;
      #1;
      tests++; if (m0_if.ARREADY !== 1'b0) begin fails++; $display("FAIL single_arready_pulse got %b exp 0", m0_if.ARREADY); end
      tests++; if (s_if.ARVALID !== 1'b1 || s_if.ARADDR !== 4'h3) begin fails++; $display("FAIL single_s_ar got v=%b a=%h exp v=1 a=3", s_if.ARVALID, s_if.ARADDR); end
      wait_rvalid(0, ok);
      tests++; if (!ok) begin fails++; $display("FAIL single_rvalid_timeout got 0 exp 1"); end
      tests++; if (m0_if.RDATA !== 32'h00000013 || m0_if.RRESP !== 2'b00) begin fails++; $display("FAIL single_rdata got %h/%b exp 00000013/00", m0_if.RDATA, m0_if.RRESP); end
      tests++; if (m1_if.RVALID !== 1'b0) begin fails++; $display("FAIL single_m1_rvalid got %b exp 0", m1_if.RVALID); end
      tick();
      #1;
      tests++; if (m0_if.RVALID !== 1'b0) begin fails++; $display("FAIL single_rvalid_drop got %b exp 0", m0_if.RVALID); end
   endtask

   task automatic test_both();
      int got[$];
      int exp_seq[3];
      exp_seq[0] = 0;
      exp_seq[1] = RR ? 1 : 0;
      exp_seq[2] = 0;
      reset_dut();
      m0_if.ARADDR = 4'h1; m0_if.ARVALID = 1'b1; m0_if.RREADY = 1'b1;
      m1_if.ARADDR = 4'h2; m1_if.ARVALID = 1'b1; m1_if.RREADY = 1'b1;
      for (int c = 0; c < 60 && got.size() < 3; c++) begin
         #1;
         if (m0_if.ARREADY === 1'b1 && m1_if.ARREADY === 1'b1) begin
            tests++; fails++; $display("FAIL both_double_grant got 11 exp one-hot");
         end
         if (m0_if.ARREADY === 1'b1) got.push_back(0);
         if (m1_if.ARREADY === 1'b1) got.push_back(1);
         if (m0_if.RVALID === 1'b1) begin
            tests++; if (m0_if.RDATA !== mem[1]) begin fails++; $display("FAIL both_m0_rdata got %h exp %h", m0_if.RDATA, mem[1]); end
         end
         if (m1_if.RVALID === 1'b1) begin
            tests++; if (m1_if.RDATA !== mem[2]) begin fails++; $display("FAIL both_m1_rdata got %h exp %h", m1_if.RDATA, mem[2]); end
         end
         tick();
      end
      m0_if.ARVALID = 1'b0;
      m1_if.ARVALID = 1'b0;
      repeat (10) tick();
      tests++; if (got.size() != 3) begin fails++; $display("FAIL both_grant_count got %0d exp 3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         tests++; if (got[i] != exp_seq[i]) begin fails++; $display("FAIL both_grant_order[%0d] got M%0d exp M%0d", i, got[i], exp_seq[i]); end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      tick();
      m1_if.ARADDR = 4'h5; m1_if.ARVALID = 1'b1; m1_if.RREADY = 1'b0;
      #1;
      tests++; if (m1_if.ARREADY !== 1'b1) begin fails++; $display("FAIL bp_m1_arready got %b exp 1", m1_if.ARREADY); end
      tick();
      m1_if.ARVALID = 1'b0;
      wait_rvalid(1, ok);
      tests++; if (!ok) begin fails++; $display("FAIL bp_rvalid_timeout got 0 exp 1"); end
      m0_if.ARADDR = 4'h8; m0_if.RREADY = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         m0_if.ARVALID = 1'b1;
         #1;
         tests++; if (s_if.RREADY !== 1'b0) begin fails++; $display("FAIL bp_s_rready[%0d] got %b exp 0", i, s_if.RREADY); end
         tests++; if (m1_if.RVALID !== 1'b1 || s_if.RVALID !== 1'b1) begin fails++; $display("FAIL bp_rvalid_hold[%0d] got %b/%b exp 1/1", i, m1_if.RVALID, s_if.RVALID); end
         tests++; if (m1_if.RDATA !== mem[5]) begin fails++; $display("FAIL bp_rdata_hold[%0d] got %h exp %h", i, m1_if.RDATA, mem[5]); end
         tests++; if (m0_if.ARREADY !== 1'b0) begin fails++; $display("FAIL bp_no_new_grant[%0d] got %b exp 0", i, m0_if.ARREADY); end
      end
      tick();
      m1_if.RREADY = 1'b1;
      #1;
      tests++; if (s_if.RREADY !== 1'b1 || m0_if.ARREADY !== 1'b0) begin fails++; $display("FAIL bp_release got rready=%b arready=%b exp 1/0", s_if.RREADY, m0_if.ARREADY); end
      tick();
      #1;
      tests++; if (m0_if.ARREADY !== 1'b1 || m1_if.RVALID !== 1'b0) begin fails++; $display("FAIL bp_regrant got arready=%b m1_rvalid=%b exp 1/0", m0_if.ARREADY, m1_if.RVALID); end
      tick();
      m0_if.ARVALID = 1'b0;
      wait_rvalid(0, ok);
      tests++; if (!ok || m0_if.RDATA !== mem[8]) begin fails++; $display("FAIL bp_m0_followup got ok=%b %h exp 1 %h", ok, m0_if.RDATA, mem[8]); end
      tick();
   endtask

   task automatic test_slow_slave();
      int n = 0;
      ar_delay = 3;
      tick();
      tick();
      m0_if.ARADDR = 4'h7; m0_if.ARVALID = 1'b1; m0_if.RREADY = 1'b1;
      #1;
      tests++; if (m0_if.ARREADY !== 1'b1) begin fails++; $display("FAIL slow_arready got %b exp 1", m0_if.ARREADY); end
      tick();
      m0_if.ARVALID = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (s_if.ARVALID !== 1'b1) break;
         n++;
         tests++; if (s_if.ARADDR !== 4'h7 || s_if.RREADY !== 1'b1) begin fails++; $display("FAIL slow_addr_hold[%0d] got a=%h rready=%b exp 7/1", c, s_if.ARADDR, s_if.RREADY); end
         tick();
      end
      tests++; if (n != 4) begin fails++; $display("FAIL slow_arvalid_cycles got %0d exp 4", n); end
      tests++; if (m0_if.RVALID !== 1'b1 || m0_if.RDATA !== mem[7]) begin fails++; $display("FAIL slow_rdata got %b %h exp 1 %h", m0_if.RVALID, m0_if.RDATA, mem[7]); end
      ar_delay = 0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid_data();
      bit ok;
      tick();
      m0_if.ARADDR = 4'h9; m0_if.ARVALID = 1'b1; m0_if.RREADY = 1'b0;
      tick();
      m0_if.ARVALID = 1'b0;
      wait_rvalid(0, ok);
      tests++; if (!ok) begin fails++; $display("FAIL rstmid_rvalid_timeout got 0 exp 1"); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      tests++; if (m0_if.RVALID !== 1'b0 || m1_if.RVALID !== 1'b0 || s_if.ARVALID !== 1'b0) begin fails++; $display("FAIL rstmid_valids got %b%b%b exp 000", m0_if.RVALID, m1_if.RVALID, s_if.ARVALID); end
      tests++; if (s_if.RREADY !== 1'b1) begin fails++; $display("FAIL rstmid_idle got rready=%b exp 1", s_if.RREADY); end
      m0_if.RREADY = 1'b1;
      tick();
      m1_if.ARADDR = 4'hF; m1_if.ARVALID = 1'b1; m1_if.RREADY = 1'b1;
      #1;
      tests++; if (m1_if.ARREADY !== 1'b1) begin fails++; $display("FAIL rstmid_m1_arready got %b exp 1", m1_if.ARREADY); end
      tick();
      m1_if.ARVALID = 1'b0;
      wait_rvalid(1, ok);
      tests++; if (!ok || m1_if.RDATA !== mem[15] || m0_if.RVALID !== 1'b0) begin fails++; $display("FAIL rstmid_m1_data got ok=%b %h m0v=%b exp 1 %h 0", ok, m1_if.RDATA, m0_if.RVALID, mem[15]); end
      tick();
   endtask

   task automatic test_error_resp();
      bit ok;
      resp_mem[6] = 2'b10;
      tick();
      m0_if.ARADDR = 4'h6; m0_if.ARVALID = 1'b1; m0_if.RREADY = 1'b1;
      tick();
      m0_if.ARVALID = 1'b0;
      wait_rvalid(0, ok);
      tests++; if (!ok || m0_if.RRESP !== 2'b10) begin fails++; $display("FAIL err_rresp got ok=%b %b exp 1 10", ok, m0_if.RRESP); end
      tests++; if (m0_if.RDATA !== mem[6]) begin fails++; $display("FAIL err_rdata got %h exp %h", m0_if.RDATA, mem[6]); end
      resp_mem[6] = 2'b00;
      tick();
   endtask

   // Transaction-level model: one outstanding read, winner by policy, data from the memory image
   task automatic test_random();
      bit            act[2];
      bit            wr[2];
      logic [AW-1:0] ra[2];
      bit            rdy[2];
      bit            busy = 1'b0;
      int            owner = 0;
      logic [AW-1:0] oaddr = '0;
      int            prio = 0;
      int            w;
      bit            grant;
      int            cyc = 0;
      act[0] = 0; act[1] = 0; wr[0] = 0; wr[1] = 0; ra[0] = '0; ra[1] = '0;
      for (int i = 0; i < 16; i++) resp_mem[i] = 2'($urandom_range(0, 3));
      reset_dut();
      while (cyc < 500 || busy || act[0] || act[1] || wr[0] || wr[1]) begin
         if (cyc >= 700) begin
            tests++; fails++; $display("FAIL rand_drain_timeout got busy=%b exp idle", busy);
            break;
         end
         if (cyc % 50 == 0) ar_delay = $urandom_range(0, 3);
         for (int i = 0; i < 2; i++) begin
            if (cyc < 500 && !act[i] && !wr[i] && $urandom_range(0, 9) < 4) begin
               act[i] = 1'b1;
               ra[i]  = 4'($urandom_range(0, 15));
            end
            rdy[i] = ($urandom_range(0, 9) < 7) || cyc >= 500;
         end
         m0_if.ARVALID = act[0]; m0_if.ARADDR = ra[0]; m0_if.RREADY = rdy[0];
         m1_if.ARVALID = act[1]; m1_if.ARADDR = ra[1]; m1_if.RREADY = rdy[1];
         #1;
         grant = !busy && (act[0] || act[1]);
         if (act[0] && act[1]) w = RR ? prio : 0;
         else w = act[0] ? 0 : 1;
         tests++; if (m0_if.ARREADY !== (grant && w == 0)) begin fails++; $display("FAIL rand_m0_arready c%0d got %b exp %b", cyc, m0_if.ARREADY, grant && w == 0); end
         tests++; if (m1_if.ARREADY !== (grant && w == 1)) begin fails++; $display("FAIL rand_m1_arready c%0d got %b exp %b", cyc, m1_if.ARREADY, grant && w == 1); end
         if (s_if.ARVALID === 1'b1) begin
            tests++; if (!busy || s_if.ARADDR !== oaddr) begin fails++; $display("FAIL rand_s_araddr c%0d got %h exp %h", cyc, s_if.ARADDR, oaddr); end
         end
         tests++; if (m0_if.RVALID === 1'b1 && !(busy && owner == 0)) begin fails++; $display("FAIL rand_m0_stray_rvalid c%0d got 1 exp 0", cyc); end
         tests++; if (m1_if.RVALID === 1'b1 && !(busy && owner == 1)) begin fails++; $display("FAIL rand_m1_stray_rvalid c%0d got 1 exp 0", cyc); end
         if (busy && ((owner == 0 && m0_if.RVALID === 1'b1) || (owner == 1 && m1_if.RVALID === 1'b1))) begin
            tests++;
            if ((owner == 0 ? m0_if.RDATA : m1_if.RDATA) !== mem[oaddr] ||
                (owner == 0 ? m0_if.RRESP : m1_if.RRESP) !== resp_mem[oaddr]) begin
               fails++;
               $display("FAIL rand_rdata c%0d M%0d got %h/%b exp %h/%b", cyc, owner,
                        owner == 0 ? m0_if.RDATA : m1_if.RDATA, owner == 0 ? m0_if.RRESP : m1_if.RRESP,
                        mem[oaddr], resp_mem[oaddr]);
            end
            if (rdy[owner]) begin
               busy      = 1'b0;
               wr[owner] = 1'b0;
            end
         end
         if (grant) begin
            busy   = 1'b1;
            owner  = w;
            oaddr  = ra[w];
            act[w] = 1'b0;
            wr[w]  = 1'b1;
            prio   = 1 - w;
         end
         cyc++;
         tick();
      end
      m0_if.ARVALID = 1'b0;
      m1_if.ARVALID = 1'b0;
      ar_delay = 0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i]      = $urandom;
         resp_mem[i] = 2'b00;
      end
      m0_if.ARVALID = 1'b0; m0_if.ARADDR = '0; m0_if.RREADY = 1'b1;
      m1_if.ARVALID = 1'b0; m1_if.ARADDR = '0; m1_if.RREADY = 1'b1;
      test_reset();
      test_single();
      test_both();
      test_backpressure();
      test_slow_slave();
      test_reset_mid_data();
      test_error_resp();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
